if_prefetch_stage: RTL and testbench

- Instruction-fetch stage with a small prefetch queue.
- Owns the PC, issues word reads to a 1-cycle-latency synchronous instruction memory, and buffers returned {PC+4, instruction} pairs.
- Hands pairs to the IF/ID register over a valid/ready handshake.
- Takes branch redirects (PCSrc/PC_branch) from the MEM stage and accepts back-pressure so a later hazard unit can stall fetch without losing instructions.

---
 rtl/if_prefetch_stage.sv | 208 ++++++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//
// Purpose: instruction-fetch stage with a small prefetch queue. The stage owns the PC and
// issues word reads to a synchronous instruction memory with 1-cycle read latency. Each
// returned word is buffered as a {PC+4, instruction} pair. The stage hands pairs to the
// IF/ID register over a valid/ready handshake. Branch redirects from MEM flush the queue
// and drop any in-flight response.
//
// Parameters:
//   AW        - PC/address width (32).
//   RESET_PC  - PC loaded on reset.
//   DEPTH     - prefetch queue entries; must be a power of two and at least 2.
//
// Ports:
//   clock            in   rising-edge clock
//   reset_n          in   synchronous active-low reset
//   pcsrc            in   branch taken; redirect fetch to pc_branch
//   pc_branch        in   redirect target (bits [1:0] ignored)
//   imem_req         out  instruction memory read request this cycle
//   imem_addr        out  word address of the request
//   imem_rdata       in   instruction, valid the cycle after a request
//   out_valid        out  queue head valid
//   out_ready        in   IF/ID accepts the head this cycle
//   pc_plus_four_out out  PC+4 of the head instruction
//   instruction_out  out  head instruction
//
// Optional feature (macro FETCH_STATS_EN):
//   fetch_count      out  number of pops (wraps)
//   flush_count      out  number of redirects that discarded work (wraps)

module if_prefetch_stage #(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   DEPTH    = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pcsrc,
    input  logic [AW-1:0] pc_branch,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] pc_plus_four_out,
`ifdef FETCH_STATS_EN
    output logic [31:0]   instruction_out,
    output logic [31:0]   fetch_count,
    output logic [31:0]   flush_count
`else
    output logic [31:0]   instruction_out
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Architectural state
    logic [AW-1:0]   pc_q, pc_d;
    logic            rsp_pending_q, rsp_pending_d;
    logic [AW-1:0]   rsp_pc_q, rsp_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [AW-1:0]   last_pc4_q, last_pc4_d;
    logic [31:0]     last_instr_q, last_instr_d;

    // Queue storage (not reset; validity tracked by count_q)
    logic [AW-1:0]   mem_pc4_q   [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CntW:0]   inflight;
    logic            credit_ok;

    always_comb begin
        // Queue slots already claimed, including the response still on its way back.
        inflight   = {1'b0, count_q} + {{CntW{1'b0}}, rsp_pending_q};
        credit_ok  = inflight < (CntW + 1)'(DEPTH);
        issue      = reset_n && !pcsrc && credit_ok;
        push       = reset_n && rsp_pending_q && !pcsrc;
        head_valid = count_q != '0;
        pop        = reset_n && head_valid && !pcsrc && out_ready;
    end

    // Next-state logic
    always_comb begin
        pc_d          = pc_q;
        rsp_pending_d = issue;
        rsp_pc_d      = rsp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        last_pc4_d    = last_pc4_q;
        last_instr_d  = last_instr_q;

        if (pop) begin
            last_pc4_d   = mem_pc4_q[rd_ptr_q];
            last_instr_d = mem_instr_q[rd_ptr_q];
        end

        if (pcsrc) begin
            // Redirect: flush everything, force word alignment of the target.
            pc_d     = pc_branch & ~AW'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + AW'(4);
                rsp_pc_d = pc_q;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            count_d  = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            rsp_pending_q <= 1'b0;
            rsp_pc_q      <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            last_pc4_q    <= '0;
            last_instr_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            last_pc4_q    <= last_pc4_d;
            last_instr_q  <= last_instr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc4_q[wr_ptr_q]   <= rsp_pc_q + AW'(4);
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Outputs. Head data falls back to the last popped pair when the queue is empty,
    // and everything reads as idle while reset is asserted.
    always_comb begin
        imem_req         = issue;
        imem_addr        = reset_n ? pc_q : RESET_PC;
        out_valid        = reset_n && head_valid && !pcsrc;
        pc_plus_four_out = '0;
        instruction_out  = '0;
        if (reset_n) begin
            if (head_valid) begin
                pc_plus_four_out = mem_pc4_q[rd_ptr_q];
                instruction_out  = mem_instr_q[rd_ptr_q];
            end else begin
                pc_plus_four_out = last_pc4_q;
                instruction_out  = last_instr_q;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
        flush_count_d = flush_count_q;
        // Only count redirects that actually threw work away.
        if (pcsrc && (head_valid || rsp_pending_q)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

`ifndef SYNTHESIS
    // The credit check must make this impossible.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(push && count_q == CntW'(DEPTH)))
                else $error("if_prefetch_stage: push into a full queue");
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pcsrc;
    logic [31:0] pc_branch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_plus_four_out;
    logic [31:0] instruction_out;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    if_prefetch_stage #(
        .AW       (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pcsrc            (pcsrc),
        .pc_branch        (pc_branch),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .pc_plus_four_out (pc_plus_four_out),
`ifdef FETCH_STATS_EN
        .instruction_out  (instruction_out),
        .fetch_count      (fetch_count),
        .flush_count      (flush_count)
`else
        .instruction_out  (instruction_out)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous memory: word i holds 32'h1000_0000 + i, one cycle of read latency.
    always @(posedge clock) imem_rdata <= 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset release).
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        pcsrc   = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        pcsrc     = 1'b0;
        pc_branch = 32'h0;
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: valid=%b req=%b, expected 0/0", out_valid, imem_req);
        end
        n_vec++;
        if (imem_addr !== 32'h0 || pc_plus_four_out !== 32'h0 || instruction_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h pc4=%h instr=%h, expected all 0",
                     imem_addr, pc_plus_four_out, instruction_out);
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cycle0: req=%b addr=%h valid=%b, expected 1/00000000/0",
                     imem_req, imem_addr, out_valid);
        end
    endtask

    // Continues straight from test_reset, cycle 0 already checked.
    task automatic test_stream();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            #1;
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL stream_issue c%0d: req=%b addr=%h, expected 1/%h",
                         k, imem_req, imem_addr, 32'(4 * k));
            end
            n_vec++;
            if (out_valid !== (k >= 2)) begin
                n_err++;
                $display("FAIL stream_valid c%0d: got %b expected %b", k, out_valid, k >= 2);
            end
            if (k >= 2) begin
                n_vec++;
                if (pc_plus_four_out !== 32'(4 * (k - 1)) ||
                    instruction_out !== 32'h1000_0000 + 32'(k - 2)) begin
                    n_err++;
                    $display("FAIL stream_data c%0d: pc4=%h instr=%h, expected %h/%h", k,
                             pc_plus_four_out, instruction_out, 32'(4 * (k - 1)),
                             32'h1000_0000 + 32'(k - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic exp_req;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clock);
            out_ready = !(k >= 2 && k <= 11);
            #1;
            exp_req = (k <= 3) || (k >= 13);
            n_vec++;
            if (imem_req !== exp_req) begin
                n_err++;
                $display("FAIL bp_req c%0d: got %b expected %b", k, imem_req, exp_req);
            end
            n_vec++;
            if (out_valid !== (k >= 2)) begin
                n_err++;
                $display("FAIL bp_valid c%0d: got %b expected %b", k, out_valid, k >= 2);
            end
            if (k >= 2 && k <= 11) begin
                n_vec++;
                if (pc_plus_four_out !== 32'h4 || instruction_out !== 32'h1000_0000) begin
                    n_err++;
                    $display("FAIL bp_hold c%0d: pc4=%h instr=%h, expected 4/10000000",
                             k, pc_plus_four_out, instruction_out);
                end
            end else if (k >= 12) begin
                n_vec++;
                if (pc_plus_four_out !== 32'(4 * (k - 11)) ||
                    instruction_out !== 32'h1000_0000 + 32'(k - 12)) begin
                    n_err++;
                    $display("FAIL bp_drain c%0d: pc4=%h instr=%h, expected %h/%h", k,
                             pc_plus_four_out, instruction_out, 32'(4 * (k - 11)),
                             32'h1000_0000 + 32'(k - 12));
                end
            end
        end
    endtask

    // Redirect with 3 queued + 1 pending, then a held pcsrc ending on a misaligned target.
    task automatic test_redirect();
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(negedge clock);
            out_ready = (k >= 5);
            pcsrc     = (k == 4) || (k == 9) || (k == 10);
            pc_branch = (k == 4) ? 32'h40 : (k == 9) ? 32'h200 : 32'h83;
            #1;
            case (k)
                3: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || imem_req !== 1'b1) begin
                        n_err++;
                        $display("FAIL redir_pre: valid=%b req=%b, expected 1/1",
                                 out_valid, imem_req);
                    end
                end
                4, 9, 10: begin
                    n_vec++;
                    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
                        n_err++;
                        $display("FAIL redir_cycle c%0d: valid=%b req=%b, expected 0/0",
                                 k, out_valid, imem_req);
                    end
                end
                5: begin
                    n_vec++;
                    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL redir_target: req=%b addr=%h valid=%b, expected 1/40/0",
                                 imem_req, imem_addr, out_valid);
                    end
                end
                6: begin
                    n_vec++;
                    if (out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL redir_stale: valid=%b expected 0", out_valid);
                    end
                end
                7, 8: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || pc_plus_four_out !== 32'h44 + 32'(4 * (k - 7)) ||
                        instruction_out !== 32'h1000_0010 + 32'(k - 7)) begin
                        n_err++;
                        $display("FAIL redir_head c%0d: valid=%b pc4=%h instr=%h", k,
                                 out_valid, pc_plus_four_out, instruction_out);
                    end
                end
                11, 12: begin
                    n_vec++;
                    if (imem_addr !== 32'h80 + 32'(4 * (k - 11)) || out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL misalign_addr c%0d: addr=%h valid=%b, expected %h/0",
                                 k, imem_addr, out_valid, 32'h80 + 32'(4 * (k - 11)));
                    end
                end
                13: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || pc_plus_four_out !== 32'h84 ||
                        instruction_out !== 32'h1000_0020) begin
                        n_err++;
                        $display("FAIL misalign_head: valid=%b pc4=%h instr=%h, expected 1/84/10000020",
                                 out_valid, pc_plus_four_out, instruction_out);
                    end
                end
                default: ;
            endcase
        end
        pcsrc = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clock);
            reset_n   = (k != 6);
            out_ready = (k >= 7);
            #1;
            case (k)
                5: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || imem_req !== 1'b0) begin
                        n_err++;
                        $display("FAIL rstmid_full: valid=%b req=%b, expected 1/0",
                                 out_valid, imem_req);
                    end
                end
                6: begin
                    n_vec++;
                    if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
                        pc_plus_four_out !== 32'h0) begin
                        n_err++;
                        $display("FAIL rstmid_during: valid=%b req=%b addr=%h pc4=%h", out_valid,
                                 imem_req, imem_addr, pc_plus_four_out);
                    end
                end
                7, 8: begin
                    n_vec++;
                    if (out_valid !== 1'b0 || imem_req !== 1'b1 ||
                        imem_addr !== 32'(4 * (k - 7)) || pc_plus_four_out !== 32'h0) begin
                        n_err++;
                        $display("FAIL rstmid_restart c%0d: valid=%b req=%b addr=%h pc4=%h", k,
                                 out_valid, imem_req, imem_addr, pc_plus_four_out);
                    end
                end
                9: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || pc_plus_four_out !== 32'h4 ||
                        instruction_out !== 32'h1000_0000) begin
                        n_err++;
                        $display("FAIL rstmid_head: valid=%b pc4=%h instr=%h, expected 1/4/10000000",
                                 out_valid, pc_plus_four_out, instruction_out);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(negedge clock);
            pcsrc     = (k == 3);
            pc_branch = 32'hFFFF_FFFC;
            #1;
            case (k)
                3: begin
                    n_vec++;
                    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
                        n_err++;
                        $display("FAIL wrap_redir: valid=%b req=%b, expected 0/0",
                                 out_valid, imem_req);
                    end
                end
                4: begin
                    n_vec++;
                    if (imem_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0 ||
                        pc_plus_four_out !== 32'h4 || instruction_out !== 32'h1000_0000) begin
                        n_err++;
                        $display("FAIL wrap_target: addr=%h valid=%b pc4=%h instr=%h", imem_addr,
                                 out_valid, pc_plus_four_out, instruction_out);
                    end
`ifdef FETCH_STATS_EN
                    n_vec++;
                    if (flush_count !== 32'd1 || fetch_count !== 32'd1) begin
                        n_err++;
                        $display("FAIL wrap_stats: flush=%0d fetch=%0d, expected 1/1",
                                 flush_count, fetch_count);
                    end
`endif
                end
                5: begin
                    n_vec++;
                    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
                        n_err++;
                        $display("FAIL wrap_pc: addr=%h req=%b, expected 0/1",
                                 imem_addr, imem_req);
                    end
                end
                6, 7: begin
                    n_vec++;
                    if (out_valid !== 1'b1 || pc_plus_four_out !== 32'(4 * (k - 6)) ||
                        instruction_out !== ((k == 6) ? 32'h4FFF_FFFF : 32'h1000_0000)) begin
                        n_err++;
                        $display("FAIL wrap_head c%0d: valid=%b pc4=%h instr=%h", k,
                                 out_valid, pc_plus_four_out, instruction_out);
                    end
                end
                default: ;
            endcase
        end
        pcsrc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
